// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU definitions: bus width, fetch state encoding, redirect kinds and opcodes.
// Imported by the fetch controller, instruction ROM and decoder.
package fetch_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_SKIP = 2'd1,
        REDIR_JUMP = 2'd2,
        REDIR_RSVD = 2'd3
    } redir_kind_e;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_BEQ = 4'd2;
    localparam logic [3:0] OP_BNE = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;

    // A taken BEQ/BNE skips the instruction that follows the branch.
    localparam logic [XLEN-1:0] SKIP_OFFSET = 32'd2;

    function automatic logic redir_kind_active(input logic [1:0] kind);
        return (kind == REDIR_SKIP) || (kind == REDIR_JUMP);
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the ROM address from the PC and issues one
// registered instruction per cycle to decode, with stall, redirect, halt and end-of-program handling.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'd0,
    parameter logic [XLEN-1:0] PC_LIMIT = 32'd255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt,
    output logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] romInst,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] instPc,
    output logic            instValid,
    input  logic            instReady,
    input  logic            redirValid,
    input  logic [1:0]      redirKind,
    input  logic [XLEN-1:0] redirBase,
    input  logic [XLEN-1:0] redirTarget,
    output logic            done
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic            done_q, done_d;
    logic            redir_hit_s;
    logic [XLEN-1:0] redir_pc_s;

    // Next-state, next-PC and issue-register logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q & ~instReady;

        redir_hit_s = redirValid && redir_kind_active(redirKind) && (state_q != ST_DONE);
        if (redirKind == REDIR_SKIP) begin
            redir_pc_s = redirBase + SKIP_OFFSET;
        end else begin
            redir_pc_s = redirTarget;
        end

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d      = ST_HALT;
                    inst_valid_d = 1'b0;
                end else if (redir_hit_s) begin
                    state_d = ST_RUN;
                end else if (pc_q > PC_LIMIT) begin
                    state_d = ST_DONE;
                end else if (!inst_valid_q || instReady) begin
                    inst_d       = romInst;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + 32'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A redirect overrides any fetch and flushes the issued instruction.
        if (redir_hit_s) begin
            pc_d         = redir_pc_s;
            inst_valid_d = 1'b0;
        end else begin
            pc_d = pc_d;
        end

        done_d = (state_d == ST_DONE);
    end

    // State, PC and issue registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            done_q       <= done_d;
        end
    end

    assign address   = pc_q;
    assign inst      = inst_q;
    assign instPc    = inst_pc_q;
    assign instValid = inst_valid_q;
    assign done      = done_q;

endmodule
